// File: rtl/game_stats_bcd.sv
// game_stats_bcd: speed / fuel / score tracker for the racing-game HUD, with collision hold-off FSM.
// Ports: clk, resetN (async active-low); startOfFrame, onesec, fueltank pulses; collision level;
//   playerSpeed[3:0]; outputs score_bcd, fuel_bcd, speed_bcd, fuel_zero, win (+ time_bcd with LAP_TIMER_EN).
// Latency: every event is visible on the outputs one cycle after it is sampled.
// Optional feature macro: LAP_TIMER_EN adds the mm:ss BCD lap timer and the time_bcd port.
module game_stats_bcd #(
   parameter int SCORE_DIGITS  = 4,
   parameter int TARGET_SCORE  = 500,
   parameter int FUEL_MAX      = 99,
   parameter int SPEED_SCALE   = 40,
   parameter int SPEED_STEP    = 2,
   parameter int HIGH_THRESH   = 5,
   parameter int BURN_HIGH     = 3,
   parameter int BURN_LOW      = 2,
   parameter int BURN_IDLE     = 1,
   parameter int CRASH_PENALTY = 10,
   parameter int REFUEL_AMOUNT = 20,
   parameter int HOLDOFF_SEC   = 1
) (
   input  logic                      clk,
   input  logic                      resetN,
   input  logic                      startOfFrame,
   input  logic                      onesec,
   input  logic                      collision,
   input  logic                      fueltank,
   input  logic [3:0]                playerSpeed,
   output logic [4*SCORE_DIGITS-1:0] score_bcd,
   output logic [7:0]                fuel_bcd,
   output logic [11:0]               speed_bcd,
   output logic                      fuel_zero,
   output logic                      win
`ifdef LAP_TIMER_EN
   ,
   output logic [15:0]               time_bcd
`endif
);

   function automatic int pow10(input int n);
      int r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   localparam int SCORE_MAX = pow10(SCORE_DIGITS) - 1;
   localparam int SCORE_W   = $clog2(SCORE_MAX + 1);
   localparam logic [SCORE_W:0]          SCORE_MAX_V = SCORE_MAX[SCORE_W:0];
   localparam logic [4*SCORE_DIGITS-1:0] ALL_NINES   = {SCORE_DIGITS{4'h9}};
   localparam logic signed [9:0]         FUEL_MAX_S  = 10'(FUEL_MAX);
   localparam logic [9:0]                STEP        = 10'(SPEED_STEP);
   localparam logic [3:0]                HOLD_MAX    = 4'(HOLDOFF_SEC);
   localparam logic [3:0]                HOLD_LAST   = 4'(HOLDOFF_SEC - 1);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_HOLDOFF = 2'd1,
      ST_OVER    = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [3:0]                hold_q, hold_d;
   logic [6:0]                fuel_q, fuel_d;
   logic [9:0]                speed_q, speed_d;
   logic [SCORE_W-1:0]        score_bin_q, score_bin_d;
   logic [4*SCORE_DIGITS-1:0] score_bcd_q, score_bcd_d;
   logic                      fuel_zero_q, fuel_zero_d;
   logic                      win_q, win_d;

   // FSM decodes
   logic crash_acc;   // collision accepted this cycle (RUN only)
   logic in_over;
   logic in_play;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (collision) state_d = ST_HOLDOFF;
         end
         ST_HOLDOFF: begin
            // Leave only on a second pulse once the hold-off has elapsed and the
            // player is clear; otherwise wait for the next pulse.
            if (onesec && (hold_q >= HOLD_LAST) && !collision) state_d = ST_RUN;
         end
         ST_OVER: state_d = ST_OVER;
         default: state_d = ST_RUN;
      endcase
      if (fuel_d == 7'd0) state_d = ST_OVER;
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      crash_acc = 1'b0;
      in_over   = 1'b0;
      case (state_q)
         ST_RUN:  crash_acc = collision;
         ST_OVER: in_over   = 1'b1;
         default: ;
      endcase
      in_play = ~in_over;
   end

   // Hold-off second counter, saturating at HOLDOFF_SEC while collision persists.
   always_comb begin
      hold_d = hold_q;
      if (crash_acc) begin
         hold_d = 4'd0;
      end else if (state_q == ST_HOLDOFF && onesec && hold_q < HOLD_MAX) begin
         hold_d = hold_q + 4'd1;
      end
   end

   // ---------------- Fuel ----------------
   logic [7:0]        refuel, penalty, burn;
   logic signed [9:0] fuel_sum;

   always_comb begin
      if (int'(playerSpeed) > HIGH_THRESH) burn = 8'(BURN_HIGH);
      else if (playerSpeed != 4'd0)        burn = 8'(BURN_LOW);
      else                                 burn = 8'(BURN_IDLE);
      refuel  = (fueltank && in_play) ? 8'(REFUEL_AMOUNT) : 8'd0;
      penalty = crash_acc             ? 8'(CRASH_PENALTY) : 8'd0;
      if (!(onesec && in_play)) burn = 8'd0;
      // All same-cycle events are summed before clamping, so order does not matter.
      fuel_sum = $signed({3'b000, fuel_q}) + $signed({2'b00, refuel})
               - $signed({2'b00, penalty}) - $signed({2'b00, burn});
      if (fuel_sum < 10'sd0)           fuel_d = 7'd0;
      else if (fuel_sum > FUEL_MAX_S)  fuel_d = FUEL_MAX_S[6:0];
      else                             fuel_d = fuel_sum[6:0];
   end

   // ---------------- Speed ----------------
   logic [9:0] speed_tgt;

   always_comb begin
      speed_tgt = in_over ? 10'd0 : 10'(int'(playerSpeed) * SPEED_SCALE);
      speed_d   = speed_q;
      if (crash_acc) begin
         speed_d = 10'd0;
      end else if (startOfFrame) begin
         if (speed_q < speed_tgt) begin
            speed_d = (speed_tgt - speed_q <= STEP) ? speed_tgt : speed_q + STEP;
         end else if (speed_q > speed_tgt) begin
            speed_d = (speed_q - speed_tgt <= STEP) ? speed_tgt : speed_q - STEP;
         end
      end
   end

   // ---------------- Score ----------------
   logic [SCORE_W:0]          score_sum;
   logic [SCORE_W:0]          ps_ext;
   logic [4*SCORE_DIGITS-1:0] bcd_sum;
   logic [4:0]                carry;
   logic [4:0]                dsum;

   always_comb begin
      ps_ext      = '0;
      ps_ext[3:0] = playerSpeed;
      score_sum   = {1'b0, score_bin_q} + ps_ext;
      // Decimal ripple add: playerSpeed enters digit 0 directly (up to 9+15=24),
      // so the first carry can be 2; later carries are 0 or 1.
      bcd_sum = score_bcd_q;
      carry   = {1'b0, playerSpeed};
      dsum    = 5'd0;
      for (int i = 0; i < SCORE_DIGITS; i++) begin
         dsum = {1'b0, score_bcd_q[4*i +: 4]} + carry;
         if (dsum >= 5'd20) begin
            bcd_sum[4*i +: 4] = 4'(dsum - 5'd20);
            carry             = 5'd2;
         end else if (dsum >= 5'd10) begin
            bcd_sum[4*i +: 4] = 4'(dsum - 5'd10);
            carry             = 5'd1;
         end else begin
            bcd_sum[4*i +: 4] = dsum[3:0];
            carry             = 5'd0;
         end
      end
      score_bin_d = score_bin_q;
      score_bcd_d = score_bcd_q;
      if (onesec && in_play) begin
         if (score_sum > SCORE_MAX_V || carry != 5'd0) begin
            score_bin_d = SCORE_MAX_V[SCORE_W-1:0];
            score_bcd_d = ALL_NINES;
         end else begin
            score_bin_d = score_sum[SCORE_W-1:0];
            score_bcd_d = bcd_sum;
         end
      end
   end

   // ---------------- Sticky flags ----------------
   always_comb begin
      fuel_zero_d = fuel_zero_q | (fuel_d == 7'd0);
      win_d       = win_q | (int'(score_bin_d) >= TARGET_SCORE);
   end

   // ---------------- Datapath registers ----------------
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         hold_q      <= 4'd0;
         fuel_q      <= FUEL_MAX_S[6:0];
         speed_q     <= 10'd0;
         score_bin_q <= '0;
         score_bcd_q <= '0;
         fuel_zero_q <= 1'b0;
         win_q       <= 1'b0;
      end else begin
         hold_q      <= hold_d;
         fuel_q      <= fuel_d;
         speed_q     <= speed_d;
         score_bin_q <= score_bin_d;
         score_bcd_q <= score_bcd_d;
         fuel_zero_q <= fuel_zero_d;
         win_q       <= win_d;
      end
   end

`ifdef LAP_TIMER_EN
   // mm:ss BCD timer, saturating at 99:59.
   logic [15:0] time_q, time_d;

   always_comb begin
      time_d = time_q;
      if (onesec && in_play && time_q != 16'h9959) begin
         if (time_q[3:0] != 4'd9) begin
            time_d[3:0] = time_q[3:0] + 4'd1;
         end else begin
            time_d[3:0] = 4'd0;
            if (time_q[7:4] != 4'd5) begin
               time_d[7:4] = time_q[7:4] + 4'd1;
            end else begin
               time_d[7:4] = 4'd0;
               if (time_q[11:8] != 4'd9) begin
                  time_d[11:8] = time_q[11:8] + 4'd1;
               end else begin
                  time_d[11:8]  = 4'd0;
                  time_d[15:12] = time_q[15:12] + 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) time_q <= 16'h0000;
      else         time_q <= time_d;
   end

   assign time_bcd = time_q;
`endif

   // ---------------- Output formatting ----------------
   assign score_bcd = score_bcd_q;
   assign fuel_bcd  = {4'(fuel_q / 7'd10), 4'(fuel_q % 7'd10)};
   assign speed_bcd = {4'(speed_q / 10'd100), 4'((speed_q / 10'd10) % 10'd10), 4'(speed_q % 10'd10)};
   assign fuel_zero = fuel_zero_q;
   assign win       = win_q;

endmodule
